// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit:
// state encoding, PC and instruction widths.
package fetch_unit_pkg;

  localparam int PC_W  = 4;
  localparam int IW    = 16;
  localparam int CNT_W = 8;

  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [IW-1:0]    ins_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: load beats increment; flags
// the 15->0 rollover of an increment.
module pc_counter
  import fetch_unit_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic ld_i,
  input  pc_t  ld_val_i,
  input  logic inc_i,
  output pc_t  pc_o,
  output logic wrap_o
);

  pc_t pc_q;
  pc_t pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld_i)
      pc_d = ld_val_i;
    else if (inc_i)
      pc_d = pc_q + pc_t'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  assign pc_o   = pc_q;
  assign wrap_o = inc_i && !ld_i
               && (pc_q == '1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: feeds one IR slot to the
// decoder with stall, redirect and halt handling.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            RUN,
  output logic [PC_W-1:0] PC,
  input  logic [IW-1:0]   INS,
  output logic [IW-1:0]   IR,
  output logic [PC_W-1:0] IR_PC,
  output logic            IR_VALID,
  input  logic            IR_READY,
  input  logic            JMP_EN,
  input  logic [PC_W-1:0] JMP_ADDR,
  input  logic            HALT_REQ,
  output logic            HALTED,
  output logic            WRAP,
  output logic [CNT_W-1:0] FCNT
);

  state_e state_q;
  ins_t   ir_q;
  pc_t    ir_pc_q;
  logic   vld_q;
  logic   halted_q;
  logic   wrap_q;
  cnt_t   fcnt_q;

  logic in_fetch;
  logic xfer;
  logic jmp_go;
  logic cap;
  logic pc_wrap;
  pc_t  pc;

  assign in_fetch = (state_q == S_FETCH);
  assign xfer     = vld_q && IR_READY;
  // halt outranks a redirect, which outranks capture
  assign jmp_go   = in_fetch && !HALT_REQ
                 && JMP_EN;
  assign cap      = in_fetch && !HALT_REQ
                 && !JMP_EN
                 && (!vld_q || xfer);

  pc_counter u_pc (
    .clk_i    (CLK),
    .rst_i    (RST),
    .ld_i     (jmp_go),
    .ld_val_i (JMP_ADDR),
    .inc_i    (cap),
    .pc_o     (pc),
    .wrap_o   (pc_wrap)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      ir_pc_q  <= '0;
      vld_q    <= 1'b0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      wrap_q <= pc_wrap;
      if (xfer)
        fcnt_q <= sat_inc(fcnt_q);
      unique case (state_q)
        S_IDLE: begin
          if (RUN)
            state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (HALT_REQ) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
            vld_q    <= 1'b0;
          end else if (JMP_EN) begin
            vld_q <= 1'b0;
          end else if (cap) begin
            ir_q    <= INS;
            ir_pc_q <= pc;
            vld_q   <= 1'b1;
          end
        end
        S_HALT: begin
          if (!RUN) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          halted_q <= 1'b0;
          vld_q    <= 1'b0;
        end
      endcase
    end
  end

  assign PC       = pc;
  assign IR       = ir_q;
  assign IR_PC    = ir_pc_q;
  assign IR_VALID = vld_q;
  assign HALTED   = halted_q;
  assign WRAP     = wrap_q;
  assign FCNT     = fcnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench: expected decoder words are queued
// and checked by a monitor on every transfer.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RUN;
  logic [3:0]  PC;
  logic [15:0] INS;
  logic [15:0] IR;
  logic [3:0]  IR_PC;
  logic        IR_VALID;
  logic        IR_READY;
  logic        JMP_EN;
  logic [3:0]  JMP_ADDR;
  logic        HALT_REQ;
  logic        HALTED;
  logic        WRAP;
  logic [7:0]  FCNT;

  logic [15:0] rom [16];
  logic [19:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  always #20 CLK = ~CLK;

  assign INS = rom[PC];

  fetch_unit dut (
    .CLK      (CLK),
    .RST      (RST),
    .RUN      (RUN),
    .PC       (PC),
    .INS      (INS),
    .IR       (IR),
    .IR_PC    (IR_PC),
    .IR_VALID (IR_VALID),
    .IR_READY (IR_READY),
    .JMP_EN   (JMP_EN),
    .JMP_ADDR (JMP_ADDR),
    .HALT_REQ (HALT_REQ),
    .HALTED   (HALTED),
    .WRAP     (WRAP),
    .FCNT     (FCNT)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int a);
    exp_q.push_back({rom[a], 4'(a)});
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_pc"}, 32'(PC), 0);
    chk({nm, "_ir"}, 32'(IR), 0);
    chk({nm, "_irpc"}, 32'(IR_PC), 0);
    chk({nm, "_vld"}, 32'(IR_VALID), 0);
    chk({nm, "_halted"}, 32'(HALTED), 0);
    chk({nm, "_wrap"}, 32'(WRAP), 0);
    chk({nm, "_fcnt"}, 32'(FCNT), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1; RUN = 1'b0; IR_READY = 1'b0;
    JMP_EN = 1'b0; JMP_ADDR = '0;
    HALT_REQ = 1'b0;
    tick(); tick();
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!RST && IR_VALID && IR_READY) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL xfer_unexp: got %0h@%0d want none",
                 IR, IR_PC);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("xfer_ir", 32'(IR), 32'(e[19:4]));
        chk("xfer_pc", 32'(IR_PC), 32'(e[3:0]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++)
      rom[i] = 16'hE000 + 16'(i * 16'h0111);
    rom[0] = 16'h0200;
    rom[1] = 16'h021F;
    rom[5] = 16'h0017;

    // basic stream
    do_reset();
    chk_reset("rst0");
    push(0); push(1);
    RUN = 1'b1; IR_READY = 1'b1;
    tick(); tick();
    chk("s1_ir0", 32'(IR), 32'h0200);
    tick();
    chk("s1_ir1", 32'(IR), 32'h021F);
    chk("s1_irpc1", 32'(IR_PC), 1);
    tick();
    IR_READY = 1'b0;
    chk("s1_fcnt", 32'(FCNT), 2);
    chk("s1_qempty", 32'(exp_q.size()), 0);

    // stall
    do_reset();
    RUN = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s2_ir", 32'(IR), 32'h0200);
      chk("s2_irpc", 32'(IR_PC), 0);
      chk("s2_pc", 32'(PC), 1);
    end
    push(0); push(1);
    IR_READY = 1'b1;
    tick();
    chk("s2_resume", 32'(IR), 32'h021F);
    tick();
    IR_READY = 1'b0;
    chk("s2_qempty", 32'(exp_q.size()), 0);

    // redirect flushes the pending word
    do_reset();
    RUN = 1'b1;
    tick(); tick();
    JMP_EN = 1'b1; JMP_ADDR = 4'd5;
    tick();
    JMP_EN = 1'b0;
    chk("s3_flush", 32'(IR_VALID), 0);
    chk("s3_pc", 32'(PC), 5);
    tick();
    chk("s3_ir", 32'(IR), 32'h0017);
    chk("s3_irpc", 32'(IR_PC), 5);
    push(5);
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;
    chk("s3_qempty", 32'(exp_q.size()), 0);

    // wrap
    do_reset();
    RUN = 1'b1;
    tick(); tick();
    JMP_EN = 1'b1; JMP_ADDR = 4'd14;
    tick();
    JMP_EN = 1'b0;
    push(14); push(15); push(0);
    IR_READY = 1'b1;
    tick();
    chk("s4_irpc14", 32'(IR_PC), 14);
    chk("s4_wrap_a", 32'(WRAP), 0);
    tick();
    chk("s4_irpc15", 32'(IR_PC), 15);
    chk("s4_wrap_b", 32'(WRAP), 1);
    chk("s4_pc0", 32'(PC), 0);
    tick();
    chk("s4_irpc0", 32'(IR_PC), 0);
    chk("s4_wrap_c", 32'(WRAP), 0);
    tick();
    IR_READY = 1'b0;
    JMP_EN = 1'b1; JMP_ADDR = 4'd0;
    tick();
    JMP_EN = 1'b0;
    chk("s4_jwrap_a", 32'(WRAP), 0);
    tick();
    chk("s4_jwrap_b", 32'(WRAP), 0);
    chk("s4_qempty", 32'(exp_q.size()), 0);

    // halt beats jump, then reset mid-stall
    do_reset();
    RUN = 1'b1;
    tick(); tick();
    HALT_REQ = 1'b1; JMP_EN = 1'b1;
    JMP_ADDR = 4'd9;
    tick();
    HALT_REQ = 1'b0;
    chk("s5_halted", 32'(HALTED), 1);
    chk("s5_pc", 32'(PC), 1);
    chk("s5_vld", 32'(IR_VALID), 0);
    tick();
    chk("s5_hold", 32'(HALTED), 1);
    chk("s5_nojmp", 32'(PC), 1);
    RUN = 1'b0; JMP_EN = 1'b0;
    tick();
    chk("s5_idle", 32'(HALTED), 0);
    tick();
    chk("s5_idle_pc", 32'(PC), 1);
    chk("s5_idle_ir", 32'(IR), 32'h0200);
    RUN = 1'b1;
    tick(); tick();
    chk("s5_refetch", 32'(IR), 32'h021F);
    chk("s5_refetch_pc", 32'(IR_PC), 1);
    push(1);
    IR_READY = 1'b1;
    tick();
    IR_READY = 1'b0;
    chk("s5_fcnt", 32'(FCNT), 1);
    JMP_EN = 1'b1; JMP_ADDR = 4'd7;
    HALT_REQ = 1'b1; RST = 1'b1;
    tick();
    chk_reset("rst_mid");
    RST = 1'b0; JMP_EN = 1'b0;
    HALT_REQ = 1'b0; RUN = 1'b0;
    chk("s5_qempty", 32'(exp_q.size()), 0);

    // saturation
    do_reset();
    for (int i = 0; i < 300; i++)
      push(i % 16);
    RUN = 1'b1; IR_READY = 1'b1;
    tick(); tick();
    repeat (300) tick();
    IR_READY = 1'b0;
    chk("s6_fcnt", 32'(FCNT), 255);
    chk("s6_qempty", 32'(exp_q.size()), 0);

    tick();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
